lsu_mem_stage: RTL

//  Load/store unit of the MEM stage: accepts one memory request per handshake from EX/MEM and drives
//  the data cache (word address out, combinational read data back, byte-enabled write).

---
 rtl/lsu_mem_stage_pkg.sv | 52 +++++
 rtl/lsu_mem_stage_load_align.sv | 41 ++++
 rtl/lsu_mem_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_pkg
// Description : Shared definitions for the MEM-stage load/store unit.
//               Holds the RV32I load/store width codes, the data width,
//               the LSU state encoding, the registered request record and
//               a misalignment helper.
//               Optional feature macro: LSU_MISALIGN_TRAP_EN. The macro is
//               not referenced here; the helper is used only when it is set.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_mem_stage_pkg;

    localparam int XLEN = 32;

    // funct3 width/sign codes (loads and stores share the encoding space)
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // LSU state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Request captured at the EX/MEM handshake
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } lsu_req_t;

    // Halfwords need addr[0]=0; words (and the undefined codes, which act
    // as words) need both low bits clear. Bytes are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: is_misaligned = 1'b0;
            FUNCT3_LH, FUNCT3_LHU: is_misaligned = addr_lo[0];
            default:               is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_load_align
// Description : Combinational load aligner. Picks the addressed byte or
//               halfword out of the dcache word and sign/zero-extends it.
//               Undefined funct3 codes pass the whole word through.
// Ports       : rdata    in  32  dcache word
//               addr_lo  in  2   byte offset within the word
//               funct3   in  3   load width/sign code
//               load_val out 32  extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage_load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{addr_lo, 3'b000} +: 8];
        // addr[0] is ignored for halfwords: a misaligned halfword is
        // silently aligned down unless the trap build blocks it upstream.
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            FUNCT3_LB:  load_val = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LBU: load_val = {24'h0, w_byte};
            FUNCT3_LH:  load_val = {{16{w_half[15]}}, w_half};
            FUNCT3_LHU: load_val = {16'h0, w_half};
            FUNCT3_LW:  load_val = rdata;
            default:    load_val = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : MEM-stage load/store unit. Accepts one request per
//               handshake, performs a single dcache access one cycle later
//               and presents the result to WB until it is taken.
//               IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
//               Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined,
//               misaligned halfword/word accesses skip the dcache write and
//               report resp_misalign=1 with zero data and rd.
// Ports       : clock, reset (async, active-high)
//               req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata/
//               req_rd      - request from EX/MEM
//               resp_valid/resp_ready/resp_data/resp_rd[/resp_misalign]
//                           - result to WB
//               dc_addr/dc_rdata/dc_we/dc_be/dc_wdata - dcache port
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter logic [31:0] DC_BASE = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic            resp_misalign,
`endif
    output logic [XLEN-1:0] dc_addr,
    input  logic [XLEN-1:0] dc_rdata,
    output logic            dc_we,
    output logic [3:0]      dc_be,
    output logic [XLEN-1:0] dc_wdata
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    lsu_req_t        r_req;
    logic [XLEN-1:0] r_resp_data;
    logic [4:0]      r_resp_rd;
    logic            w_accept;
    logic [XLEN-1:0] w_offs;
    logic [XLEN-1:0] w_load_val;
    logic [3:0]      w_st_be;
    logic [XLEN-1:0] w_st_wdata;
    logic            w_block;

`ifdef LSU_MISALIGN_TRAP_EN
    logic            r_resp_misalign;
    logic            w_misalign;

    assign w_misalign    = is_misaligned(r_req.funct3, r_req.addr[1:0]);
    assign w_block       = w_misalign;
    assign resp_misalign = r_resp_misalign;
`else
    assign w_block       = 1'b0;
`endif

    assign w_accept   = req_valid & req_ready;
    // Window-relative address; wraps modulo 2^32 below DC_BASE by design.
    assign w_offs     = r_req.addr - DC_BASE;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_resp_rd;

    lsu_mem_stage_load_align u_load_align (
        .rdata    (dc_rdata),
        .addr_lo  (r_req.addr[1:0]),
        .funct3   (r_req.funct3),
        .load_val (w_load_val)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   if (resp_ready) w_state_nxt = req_valid ? ST_ACCESS : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------- store lane building
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = r_req.wdata;
        case (r_req.funct3)
            FUNCT3_SB, FUNCT3_LBU: begin
                w_st_be    = 4'b0001 << r_req.addr[1:0];
                w_st_wdata = {24'h0, r_req.wdata[7:0]} << {r_req.addr[1:0], 3'b000};
            end
            FUNCT3_SH, FUNCT3_LHU: begin
                w_st_be    = r_req.addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = r_req.addr[1] ? {r_req.wdata[15:0], 16'h0}
                                           : {16'h0, r_req.wdata[15:0]};
            end
            FUNCT3_SW: begin
                w_st_be    = 4'b1111;
                w_st_wdata = r_req.wdata;
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = r_req.wdata;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Driven straight from the state register so an async reset during
    // ACCESS drops dc_we immediately.
    always_comb begin
        req_ready = 1'b0;
        dc_addr   = '0;
        dc_we     = 1'b0;
        dc_be     = 4'b0000;
        dc_wdata  = '0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_ACCESS: begin
                dc_addr = {w_offs[XLEN-1:2], 2'b00};
                if (r_req.we && !w_block) begin
                    dc_we    = 1'b1;
                    dc_be    = w_st_be;
                    dc_wdata = w_st_wdata;
                end
            end
            ST_RESP: req_ready = resp_ready;
            default: req_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------ request capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req.we     <= req_we;
            r_req.funct3 <= req_funct3;
            r_req.addr   <= req_addr;
            r_req.wdata  <= req_wdata;
            r_req.rd     <= req_rd;
        end
    end

    // ----------------------------------------------------- response capture
    // Loaded once at the end of ACCESS and then held through RESP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_data <= '0;
            r_resp_rd   <= '0;
        end else if (r_state == ST_ACCESS) begin
            if (r_req.we || w_block) begin
                r_resp_data <= '0;
                r_resp_rd   <= '0;
            end else begin
                r_resp_data <= w_load_val;
                r_resp_rd   <= r_req.rd;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_misalign <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_resp_misalign <= w_misalign;
        end
    end
`endif

endmodule
`default_nettype wire
